exp_ker_wr_ctrl: RTL and testbench

Parametrised write controller for the expand-kernel weight buffer, used by the exp 1x1 and exp 3x3 kernel controllers.
- On start_i, latches the per-fire configuration: enable, total address limit, per-layer kernel count.
- Accepts a valid/ready stream of kernel words.
- Generates buffer write strobes, addresses and a ping-pong bank select.
- Flags layer and fire boundaries.
- Sits between the config/DMA front end and the kernel RAMs.

---
 rtl/exp_ker_wr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_exp_ker_wr_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_ker_wr_ctrl.sv
// Expand-kernel weight buffer write controller.
// Latches per-fire configuration on start_i, accepts a valid/ready stream of
// kernel words, and turns each accepted word into a registered buffer write
// with address, data and ping-pong bank. Layer and fire boundaries are
// flagged on the same cycle as the write that completes them.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; ker_ready_o low
// LOAD  | streaming kernel words into the current bank; ker_ready_o high
module exp_ker_wr_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int LAYR_W    = 7,
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              exp_en_i,
    input  logic [ADDR_W-1:0] tot_ker_addr_limit_i,
    input  logic [LAYR_W-1:0] one_ker_addr_limit_i,
    input  logic              ker_valid_i,
    input  logic [DATA_W-1:0] ker_data_i,
    output logic              ker_ready_o,
    output logic              exp_en_o,
    output logic [ADDR_W-1:0] wr_addr_per_fire_o,
    output logic [LAYR_W-1:0] wr_addr_per_layr_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_bank_o,
    output logic              layr_done_o,
    output logic              fire_done_o,
    output logic              busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              exp_en_q,    exp_en_d;
    logic [ADDR_W-1:0] fire_lim_q,  fire_lim_d;
    logic [LAYR_W-1:0] layr_lim_q,  layr_lim_d;
    logic [ADDR_W-1:0] fire_cnt_q,  fire_cnt_d;
    logic [LAYR_W-1:0] layr_cnt_q,  layr_cnt_d;
    logic              bank_q,      bank_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic              wr_bank_q,   wr_bank_d;
    logic              layr_done_q, layr_done_d;
    logic              fire_done_q, fire_done_d;

    logic ready;
    logic accept;
    logic last_beat;
    logic layr_wrap;
    logic start_idle;

    // A start is only honoured in IDLE; in LOAD (including the exit cycle) it is dropped.
    assign start_idle = (state_q == IDLE) && start_i;
    assign last_beat  = (fire_cnt_q == fire_lim_q);
    assign layr_wrap  = (layr_cnt_q == layr_lim_q);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter LOAD on an enabled start, leave after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i && exp_en_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and busy decode straight from the state.
    always_comb begin
        ready  = (state_q == LOAD);
        accept = ready && ker_valid_i;
    end

    // Datapath next values: config latch, counters, bank, registered write port.
    always_comb begin
        exp_en_d    = exp_en_q;
        fire_lim_d  = fire_lim_q;
        layr_lim_d  = layr_lim_q;
        fire_cnt_d  = fire_cnt_q;
        layr_cnt_d  = layr_cnt_q;
        bank_d      = bank_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_bank_d   = wr_bank_q;
        layr_done_d = 1'b0;
        fire_done_d = 1'b0;

        if (start_idle) begin
            exp_en_d   = exp_en_i;
            fire_lim_d = tot_ker_addr_limit_i;
            // A zero words-per-layer wraps to all ones, i.e. a 2^LAYR_W word layer.
            layr_lim_d = one_ker_addr_limit_i - LAYR_W'(1);
            fire_cnt_d = '0;
            layr_cnt_d = '0;
            // A disabled fire completes immediately without touching the bank.
            if (!exp_en_i) begin
                fire_done_d = 1'b1;
            end
        end

        if (accept) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = fire_cnt_q;
            wr_data_d   = ker_data_i;
            wr_bank_d   = bank_q;
            fire_cnt_d  = fire_cnt_q + ADDR_W'(1);
            layr_cnt_d  = layr_wrap ? '0 : (layr_cnt_q + LAYR_W'(1));
            // The final word of a fire always closes its layer too.
            layr_done_d = layr_wrap || last_beat;
            fire_done_d = last_beat;
            if (last_beat) begin
                bank_d = (NUM_BANKS == 2) ? ~bank_q : 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exp_en_q    <= 1'b0;
            fire_lim_q  <= '0;
            layr_lim_q  <= '0;
            fire_cnt_q  <= '0;
            layr_cnt_q  <= '0;
            bank_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_bank_q   <= 1'b0;
            layr_done_q <= 1'b0;
            fire_done_q <= 1'b0;
        end else begin
            exp_en_q    <= exp_en_d;
            fire_lim_q  <= fire_lim_d;
            layr_lim_q  <= layr_lim_d;
            fire_cnt_q  <= fire_cnt_d;
            layr_cnt_q  <= layr_cnt_d;
            bank_q      <= bank_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_bank_q   <= wr_bank_d;
            layr_done_q <= layr_done_d;
            fire_done_q <= fire_done_d;
        end
    end

    assign ker_ready_o        = ready;
    assign busy_o             = ready;
    assign exp_en_o           = exp_en_q;
    assign wr_addr_per_fire_o = fire_lim_q;
    assign wr_addr_per_layr_o = layr_lim_q;
    assign wr_en_o            = wr_en_q;
    assign wr_addr_o          = wr_addr_q;
    assign wr_data_o          = wr_data_q;
    assign wr_bank_o          = wr_bank_q;
    assign layr_done_o        = layr_done_q;
    assign fire_done_o        = fire_done_q;

endmodule

// File: tb/tb_exp_ker_wr_ctrl.sv
// Directed, table-driven bench for the expand-kernel write controller.
// Each table row is the input set applied before one clock edge and the
// output set expected just after that edge.
module tb_exp_ker_wr_ctrl;

    localparam int ADDR_W = 12;
    localparam int LAYR_W = 7;
    localparam int DATA_W = 64;

    logic              clk_i;
    logic              rst_n_i;
    logic              start_i;
    logic              exp_en_i;
    logic [ADDR_W-1:0] tot_ker_addr_limit_i;
    logic [LAYR_W-1:0] one_ker_addr_limit_i;
    logic              ker_valid_i;
    logic [DATA_W-1:0] ker_data_i;
    logic              ker_ready_o;
    logic              exp_en_o;
    logic [ADDR_W-1:0] wr_addr_per_fire_o;
    logic [LAYR_W-1:0] wr_addr_per_layr_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_bank_o;
    logic              layr_done_o;
    logic              fire_done_o;
    logic              busy_o;

    exp_ker_wr_ctrl #(
        .ADDR_W   (ADDR_W),
        .LAYR_W   (LAYR_W),
        .DATA_W   (DATA_W),
        .NUM_BANKS(2)
    ) dut (
        .clk_i               (clk_i),
        .rst_n_i             (rst_n_i),
        .start_i             (start_i),
        .exp_en_i            (exp_en_i),
        .tot_ker_addr_limit_i(tot_ker_addr_limit_i),
        .one_ker_addr_limit_i(one_ker_addr_limit_i),
        .ker_valid_i         (ker_valid_i),
        .ker_data_i          (ker_data_i),
        .ker_ready_o         (ker_ready_o),
        .exp_en_o            (exp_en_o),
        .wr_addr_per_fire_o  (wr_addr_per_fire_o),
        .wr_addr_per_layr_o  (wr_addr_per_layr_o),
        .wr_en_o             (wr_en_o),
        .wr_addr_o           (wr_addr_o),
        .wr_data_o           (wr_data_o),
        .wr_bank_o           (wr_bank_o),
        .layr_done_o         (layr_done_o),
        .fire_done_o         (fire_done_o),
        .busy_o              (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic              start;
        logic              en;
        logic              valid;
        logic [ADDR_W-1:0] tot;
        logic [LAYR_W-1:0] one;
        logic [DATA_W-1:0] data;
        logic              x_wr_en;
        logic [ADDR_W-1:0] x_addr;
        logic [DATA_W-1:0] x_data;
        logic              x_layr;
        logic              x_fire;
        logic              x_bank;
        logic              x_busy;
        logic              x_en;
        logic [ADDR_W-1:0] x_flim;
        logic [LAYR_W-1:0] x_llim;
    } vec_t;

    vec_t vq[$];

    int total = 0;
    int bad   = 0;
    int row   = 0;

    // Expected values of held/latched outputs while the table is being built.
    logic              e_en;
    logic [ADDR_W-1:0] e_flim;
    logic [LAYR_W-1:0] e_llim;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_bank;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
        end
    endtask

    task automatic set_cfg(input logic en, input logic [ADDR_W-1:0] flim, input logic [LAYR_W-1:0] llim);
        e_en   = en;
        e_flim = flim;
        e_llim = llim;
    endtask

    task automatic add(input logic st, input logic en, input logic vl,
                       input logic [ADDR_W-1:0] tot, input logic [LAYR_W-1:0] one,
                       input logic [DATA_W-1:0] d, input logic we,
                       input logic [ADDR_W-1:0] a, input logic ly, input logic fi,
                       input logic bk, input logic bs);
        vec_t v;
        if (we) begin
            e_addr = a;
            e_data = d;
            e_bank = bk;
        end
        v.start = st;  v.en = en;  v.valid = vl;
        v.tot = tot;   v.one = one; v.data = d;
        v.x_wr_en = we; v.x_addr = e_addr; v.x_data = e_data;
        v.x_layr = ly; v.x_fire = fi; v.x_bank = e_bank; v.x_busy = bs;
        v.x_en = e_en; v.x_flim = e_flim; v.x_llim = e_llim;
        vq.push_back(v);
    endtask

    task automatic apply_all();
        foreach (vq[i]) begin
            @(negedge clk_i);
            start_i              = vq[i].start;
            exp_en_i             = vq[i].en;
            ker_valid_i          = vq[i].valid;
            tot_ker_addr_limit_i = vq[i].tot;
            one_ker_addr_limit_i = vq[i].one;
            ker_data_i           = vq[i].data;
            @(posedge clk_i);
            #1;
            chk("wr_en",     64'(wr_en_o),            64'(vq[i].x_wr_en));
            chk("wr_addr",   64'(wr_addr_o),          64'(vq[i].x_addr));
            chk("wr_data",   wr_data_o,               vq[i].x_data);
            chk("layr_done", 64'(layr_done_o),        64'(vq[i].x_layr));
            chk("fire_done", 64'(fire_done_o),        64'(vq[i].x_fire));
            chk("wr_bank",   64'(wr_bank_o),          64'(vq[i].x_bank));
            chk("busy",      64'(busy_o),             64'(vq[i].x_busy));
            chk("ker_ready", 64'(ker_ready_o),        64'(vq[i].x_busy));
            chk("exp_en",    64'(exp_en_o),           64'(vq[i].x_en));
            chk("per_fire",  64'(wr_addr_per_fire_o), 64'(vq[i].x_flim));
            chk("per_layr",  64'(wr_addr_per_layr_o), 64'(vq[i].x_llim));
            row++;
        end
        vq.delete();
        @(negedge clk_i);
        start_i     = 1'b0;
        ker_valid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},     64'(wr_en_o),            64'd0);
        chk({tag, "_wr_addr"},   64'(wr_addr_o),          64'd0);
        chk({tag, "_wr_data"},   wr_data_o,               64'd0);
        chk({tag, "_layr_done"}, 64'(layr_done_o),        64'd0);
        chk({tag, "_fire_done"}, 64'(fire_done_o),        64'd0);
        chk({tag, "_wr_bank"},   64'(wr_bank_o),          64'd0);
        chk({tag, "_busy"},      64'(busy_o),             64'd0);
        chk({tag, "_ker_ready"}, 64'(ker_ready_o),        64'd0);
        chk({tag, "_exp_en"},    64'(exp_en_o),           64'd0);
        chk({tag, "_per_fire"},  64'(wr_addr_per_fire_o), 64'd0);
        chk({tag, "_per_layr"},  64'(wr_addr_per_layr_o), 64'd0);
    endtask

    initial begin
        rst_n_i              = 1'b0;
        start_i              = 1'b0;
        exp_en_i             = 1'b0;
        tot_ker_addr_limit_i = '0;
        one_ker_addr_limit_i = '0;
        ker_valid_i          = 1'b0;
        ker_data_i           = '0;
        e_en = 1'b0; e_flim = '0; e_llim = '0;
        e_addr = '0; e_data = '0; e_bank = 1'b0;

        #12;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Fire 1: tot=7, one=4, valid held high, bank 0.
        set_cfg(1'b1, 12'd7, 7'd3);
        add(1, 1, 0, 12'd7, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            add(0, 1, 1, 12'd7, 7'd4, 64'(k), 1, 12'(k), (k == 3) || (k == 7), k == 7, 0, k != 7);
        add(0, 1, 1, 12'd7, 7'd4, 64'd99, 0, 12'd0, 0, 0, 0, 0);

        // Fire 2: same config, valid toggling, bank 1.
        add(1, 1, 0, 12'd7, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            add(0, 1, 1, 12'd7, 7'd4, 64'hA5A5_0000_0000_0000 | 64'(k), 1, 12'(k),
                (k == 3) || (k == 7), k == 7, 1, k != 7);
            if (k != 7)
                add(0, 1, 0, 12'd7, 7'd4, 64'hFFFF, 0, 12'd0, 0, 0, 0, 1);
        end
        add(0, 1, 0, 12'd7, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 0);

        // Disabled fire: immediate fire_done, no writes, no busy.
        set_cfg(1'b0, 12'd5, 7'd1);
        add(1, 0, 0, 12'd5, 7'd2, 64'd0, 0, 12'd0, 0, 1, 0, 0);
        add(0, 0, 1, 12'd5, 7'd2, 64'd7, 0, 12'd0, 0, 0, 0, 0);
        add(0, 0, 1, 12'd5, 7'd2, 64'd7, 0, 12'd0, 0, 0, 0, 0);

        // Fire 3: restart mid-fire and on the exit beat are both ignored; bank 0.
        set_cfg(1'b1, 12'd7, 7'd3);
        add(1, 1, 0, 12'd7, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            add((k == 3) || (k == 7), 1, 1, (k == 3 || k == 7) ? 12'd15 : 12'd7,
                (k == 3) ? 7'd8 : 7'd4, 64'h300 + 64'(k), 1, 12'(k),
                (k == 3) || (k == 7), k == 7, 0, k != 7);
        add(0, 1, 1, 12'd7, 7'd4, 64'd1, 0, 12'd0, 0, 0, 0, 0);
        add(0, 1, 1, 12'd7, 7'd4, 64'd1, 0, 12'd0, 0, 0, 0, 0);

        // Fire 4: one=0 gives 128-word layers, tot=255; bank 1.
        set_cfg(1'b1, 12'd255, 7'd127);
        add(1, 1, 0, 12'd255, 7'd0, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 256; k++)
            add(0, 1, 1, 12'd255, 7'd0, 64'(k) * 64'd3, 1, 12'(k),
                (k == 127) || (k == 255), k == 255, 1, k != 255);
        add(0, 1, 0, 12'd255, 7'd0, 64'd0, 0, 12'd0, 0, 0, 0, 0);

        // Fire 5: single-word fire, tot=0; bank 0.
        set_cfg(1'b1, 12'd0, 7'd0);
        add(1, 1, 0, 12'd0, 7'd1, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        add(0, 1, 1, 12'd0, 7'd1, 64'hDEAD_BEEF, 1, 12'd0, 1, 1, 0, 0);
        add(0, 1, 1, 12'd0, 7'd1, 64'd5, 0, 12'd0, 0, 0, 0, 0);

        // Fire 6 (partial): six words into bank 1, then reset.
        set_cfg(1'b1, 12'd7, 7'd3);
        add(1, 1, 0, 12'd7, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++)
            add(0, 1, 1, 12'd7, 7'd4, 64'h600 + 64'(k), 1, 12'(k), k == 3, 0, 1, 1);
        apply_all();

        // apply_all left us at a negedge; pull reset mid-cycle and look immediately.
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        e_en = 1'b0; e_flim = '0; e_llim = '0;
        e_addr = '0; e_data = '0; e_bank = 1'b0;

        // Fire 7: after reset, tot=3 writes addr 0..3 into bank 0.
        set_cfg(1'b1, 12'd3, 7'd3);
        add(1, 1, 0, 12'd3, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++)
            add(0, 1, 1, 12'd3, 7'd4, 64'h700 + 64'(k), 1, 12'(k), k == 3, k == 3, 0, k != 3);
        add(0, 1, 0, 12'd3, 7'd4, 64'd0, 0, 12'd0, 0, 0, 0, 0);
        apply_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout row=%0d actual=running required=finished", row);
        $fatal(1, "timeout");
    end

endmodule
